hilo_muldiv_unit: RTL

Multi-cycle HI/LO multiply/divide responder in the EX stage of the pipelined MIPS core. It replaces the single-cycle HI/LO path.
- Accepts mult/multu/div/divu issued by the pipeline and computes iteratively, one bit per cycle.
- Holds the HI/LO architectural registers.
- Serves mfhi/mflo reads.
- Drives stall_o to the hazard unit when the pipeline needs a result that is not yet ready, or issues a new op while one is in flight.

---
 rtl/hilo_muldiv_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative HI/LO multiply/divide unit for the EX stage
//
// Purpose: executes mult/multu/div/divu one bit per clock, owns the HI/LO
// architectural registers, serves mfhi/mflo reads and requests pipeline stalls
// while a result is not yet available.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i, op_i   issue strobe and opcode (00 div, 01 divu, 10 mult, 11 multu)
//   a_i, b_i        rs / rt operands
//   mf_i            read request (0x none, 10 mflo, 11 mfhi)
//   hl_out_o        read data, combinational from registered HI/LO
//   hi_o, lo_o      HI / LO registers
//   busy_o          operation in flight (MUL, DIV or FIX)
//   done_o          one-cycle pulse after HI/LO were written
//   stall_o         stall request to the hazard unit
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       mf_i,
  output logic [WIDTH-1:0] hl_out_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // MUL: {partial product high, remaining multiplier bits}
  // DIV: {partial remainder, dividend bits / quotient bits shifted in}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;      // multiplicand or divisor magnitude
  logic               is_mul_q, is_mul_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_trial;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_fix;
  logic               last_iter;

  assign signed_op = ~op_i[0];
  assign a_neg     = signed_op & a_i[WIDTH-1];
  assign b_neg     = signed_op & b_i[WIDTH-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;

  // Shift-add step: add multiplicand to the high half when the current
  // multiplier bit is set, then shift the whole accumulator right by one.
  assign mul_addend = acc_q[0] ? opnd_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

  // Restoring step: bring in the next dividend bit, keep the subtraction
  // only when it does not go negative. A zero divisor yields an all-ones
  // quotient and leaves the dividend as the remainder.
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign div_ge    = ~div_trial[WIDTH];
  assign div_rem   = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];

  assign prod_fix  = neg_quo_q ? -acc_q : acc_q;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_mul_d  = is_mul_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d     = '0;
          is_mul_d  = op_i[1];
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = ~op_i[1] & (b_i == '0);
          if (op_i[1]) begin
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            opnd_d  = a_mag;
            state_d = MUL;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            opnd_d  = b_mag;
            state_d = DIV;
          end
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) state_d = FIX;
      end
      DIV: begin
        acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (is_mul_q) begin
          {hi_d, lo_d} = prod_fix;
        end else begin
          // Negating the magnitude restores the raw dividend for a zero divisor.
          hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          if (div0_q) lo_d = '1;
          else        lo_d = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_mul_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_mul_q  <= is_mul_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;
  assign stall_o  = busy_o & (start_i | mf_i[1]);
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign hl_out_o = mf_i[0] ? hi_q : lo_q;

endmodule
